cva6_mem_order_ctrl: RTL and testbench

CVA6_MEM_ORDER_CTRL -- requirements
Module: cva6_mem_order_ctrl

---
 rtl/cva6_mem_order_ctrl.sv | 139 +++++++++++++
 tb/tb_cva6_mem_order_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_mem_order_ctrl.sv
// Memory ordering controller between the LSU and the HPDcache.
// Tracks outstanding stores and orders fences and non-idempotent loads.
module cva6_mem_order_ctrl #(
    parameter int unsigned MaxOutstandingStores = 7,
    parameter int unsigned CntWidth             = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic                st_ack_i,
    input  logic                ld_valid_i,
    input  logic                ld_nonidem_i,
    output logic                ld_ready_o,
    input  logic                ld_rsp_i,
    input  logic                fence_i,
    output logic                fence_done_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                underflow_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_NI_ISSUE,
        S_NI_WAIT,
        S_FENCE_DRAIN
    } state_t;

    localparam logic [CntWidth-1:0] MaxCnt =
        CntWidth'(MaxOutstandingStores);

    state_t              r_state;
    logic [CntWidth-1:0] r_cnt;
    logic                r_fence_pending;
    logic                r_underflow;

    logic w_idle;
    logic w_cnt_zero;
    logic w_st_hs;
    logic w_fence_done;
    logic w_ld_ready;

    assign w_idle       = (r_state == S_IDLE);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_st_hs      = st_valid_i & st_ready_o;
    // Done is decoded from registered state so a fence seen at count 0
    // completes in the very next cycle.
    assign w_fence_done = (r_state == S_FENCE_DRAIN) & w_cnt_zero;

    assign st_ready_o    = w_idle & ~r_fence_pending & (r_cnt < MaxCnt);
    assign ld_ready_o    = w_ld_ready;
    assign fence_done_o  = w_fence_done;
    assign outstanding_o = r_cnt;
    assign underflow_o   = r_underflow;

    // Load readiness: idempotent loads pass in IDLE, NI loads only in NI_ISSUE
    always_comb begin
        w_ld_ready = 1'b0;
        case (r_state)
            S_IDLE:
                w_ld_ready = ~r_fence_pending & ~fence_i & ~ld_nonidem_i;
            S_NI_ISSUE:
                w_ld_ready = ld_nonidem_i;
            default:
                w_ld_ready = 1'b0;
        endcase
    end

    // Outstanding-store counter, saturating, with sticky underflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_underflow <= 1'b0;
        end else begin
            case ({w_st_hs, st_ack_i})
                2'b10: begin
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + 1'b1;
                end
                2'b01: begin
                    if (w_cnt_zero)
                        r_underflow <= 1'b1;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Fence pending: fences seen outside IDLE merge until the next completion
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fence_pending <= 1'b0;
        end else if (w_fence_done) begin
            r_fence_pending <= fence_i;
        end else if (fence_i && !w_idle) begin
            r_fence_pending <= 1'b1;
        end
    end

    // Ordering FSM: fences drain stores, NI loads wait for an empty store path
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fence_i || r_fence_pending)
                        r_state <= S_FENCE_DRAIN;
                    else if (ld_valid_i && ld_nonidem_i)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_cnt_zero)
                        r_state <= S_NI_ISSUE;
                end
                S_NI_ISSUE: begin
                    if (!ld_valid_i)
                        r_state <= S_IDLE;
                    else if (w_ld_ready)
                        r_state <= S_NI_WAIT;
                end
                S_NI_WAIT: begin
                    if (ld_rsp_i)
                        r_state <= S_IDLE;
                end
                S_FENCE_DRAIN: begin
                    if (w_cnt_zero)
                        r_state <= S_IDLE;
                end
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_mem_order_ctrl.sv
// Bench for cva6_mem_order_ctrl: per-cycle vector table checked
// through an expectation queue, plus an async-reset sequence.
module tb_cva6_mem_order_ctrl;

    logic       clk;
    logic       rst_n;
    logic       st_valid;
    logic       st_ready;
    logic       st_ack;
    logic       ld_valid;
    logic       ld_nonidem;
    logic       ld_ready;
    logic       ld_rsp;
    logic       fence;
    logic       fence_done;
    logic [2:0] outstanding;
    logic       underflow;

    cva6_mem_order_ctrl #(
        .MaxOutstandingStores(7),
        .CntWidth(3)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .st_valid_i(st_valid),
        .st_ready_o(st_ready),
        .st_ack_i(st_ack),
        .ld_valid_i(ld_valid),
        .ld_nonidem_i(ld_nonidem),
        .ld_ready_o(ld_ready),
        .ld_rsp_i(ld_rsp),
        .fence_i(fence),
        .fence_done_o(fence_done),
        .outstanding_o(outstanding),
        .underflow_o(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic       ack;
        logic       lv;
        logic       ln;
        logic       rsp;
        logic       fn;
        logic       sr;
        logic       lr;
        logic       fd;
        logic [2:0] cnt;
        logic       uf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int idx,
                       input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d",
                     nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic ack,
                       input logic lv, input logic ln,
                       input logic rsp, input logic fn,
                       input logic sr, input logic lr,
                       input logic fd, input int cnt,
                       input logic uf);
        vec_t v;
        v.sv  = sv;  v.ack = ack; v.lv = lv;
        v.ln  = ln;  v.rsp = rsp; v.fn = fn;
        v.sr  = sr;  v.lr  = lr;  v.fd = fd;
        v.cnt = 3'(cnt);
        v.uf  = uf;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        st_valid   = 1'b0;
        st_ack     = 1'b0;
        ld_valid   = 1'b0;
        ld_nonidem = 1'b0;
        ld_rsp     = 1'b0;
        fence      = 1'b0;
    endtask

    initial begin
        vec_t v;
        vec_t e;

        //  sv ack lv ln rsp fn | sr lr fd cnt uf
        // store limit: 7 handshakes, 8th blocked, one ack frees a slot
        for (int i = 0; i < 7; i++)
            add(1, 0, 0, 0, 0, 0, 1, 1, 0, i, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1, 0, 7, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 6, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 5, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 4, 0);
        // simultaneous handshake and ack at count 3
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 3, 0);
        // NI load at count 2: drain, issue, wait for response
        add(0, 0, 1, 1, 0, 0, 1, 0, 0, 2, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        // fence and NI load together at count 1: fence first
        add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        // two fences during NI_WAIT merge into one done
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        // fence in the done cycle re-arms a second done
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        // stray ack at count 0
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        // valid drops in NI_ISSUE: back to IDLE
        add(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);

        drive_idle();
        rst_n = 1'b0;
        #12;
        chk("rst_st_ready", -1, 3'(st_ready), 3'd1);
        chk("rst_ld_ready", -1, 3'(ld_ready), 3'd1);
        chk("rst_fence_done", -1, 3'(fence_done), 3'd0);
        chk("rst_count", -1, outstanding, 3'd0);
        chk("rst_underflow", -1, 3'(underflow), 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            v          = tbl[i];
            st_valid   = v.sv;
            st_ack     = v.ack;
            ld_valid   = v.lv;
            ld_nonidem = v.ln;
            ld_rsp     = v.rsp;
            fence      = v.fn;
            exp_q.push_back(v);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty step=%0d", i);
            end else begin
                e = exp_q.pop_front();
                chk("st_ready", i, 3'(st_ready), 3'(e.sr));
                chk("ld_ready", i, 3'(ld_ready), 3'(e.lr));
                chk("fence_done", i, 3'(fence_done), 3'(e.fd));
                chk("count", i, outstanding, e.cnt);
                chk("underflow", i, 3'(underflow), 3'(e.uf));
            end
        end

        // async reset in the middle of a drain
        @(posedge clk);
        #1;
        drive_idle();
        st_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        st_valid   = 1'b0;
        ld_valid   = 1'b1;
        ld_nonidem = 1'b1;
        @(posedge clk);
        #3;
        chk("drain_st_ready", 100, 3'(st_ready), 3'd0);
        chk("drain_ld_ready", 100, 3'(ld_ready), 3'd0);
        chk("drain_count", 100, outstanding, 3'd2);
        chk("drain_underflow", 100, 3'(underflow), 3'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 101, outstanding, 3'd0);
        chk("arst_st_ready", 101, 3'(st_ready), 3'd1);
        chk("arst_underflow", 101, 3'(underflow), 3'd0);
        chk("arst_fence_done", 101, 3'(fence_done), 3'd0);
        chk("arst_ld_ready_ni", 101, 3'(ld_ready), 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        @(negedge clk);
        chk("post_st_ready", 102, 3'(st_ready), 3'd1);
        chk("post_ld_ready", 102, 3'(ld_ready), 3'd1);
        chk("post_count", 102, outstanding, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
